// File: rtl/rv_m_pkg.sv
// Shared definitions for the M-extension divide path.
//   wb_state_e : divide writeback tracker states
//   F3_*       : funct3 encodings of the divide/remainder instructions
//   XLEN_DEF   : default datapath width
package rv_m_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no divide outstanding
        PEND = 2'd1,  // divide in flight in div_unit
        HOLD = 2'd2   // result buffered, waiting for the write port
    } wb_state_e;

endpackage

// File: rtl/div_wb_ctrl.sv
// Divide writeback controller.
// Merges div_unit completions onto the register-file write port shared with
// the main pipeline, tracks the single outstanding divide destination and
// stalls decode on hazards against it.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   div_issue_i, div_issue_rd_i       divide accepted at decode and its rd
//   flush_i                           pipeline flush (kills an in-flight divide)
//   div_ready_i, div_rd_i, div_result_i  div_unit completion pulse
//   pipe_wb_en_i/rd_i/data_i          main pipeline writeback request
//   id_rs1_i, id_rs2_i, id_rd_i, id_is_div_i  decode operands for hazard check
//   rf_we_o, rf_rd_o, rf_wdata_o      register-file write port
//   id_stall_o                        stall decode
//   pipe_wb_stall_o                   pipeline writeback pre-empted this cycle
module div_wb_ctrl
    import rv_m_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned XLEN     = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            div_issue_i,
    input  logic [4:0]      div_issue_rd_i,
    input  logic            flush_i,
    input  logic            div_ready_i,
    input  logic [4:0]      div_rd_i,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            pipe_wb_en_i,
    input  logic [4:0]      pipe_wb_rd_i,
    input  logic [XLEN-1:0] pipe_wb_data_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    input  logic            id_is_div_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            id_stall_o,
    output logic            pipe_wb_stall_o
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    wb_state_e       state_q, state_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;

    // Divide-side write request for this cycle (write-through or buffer drain).
    logic            div_wr;
    logic [4:0]      div_wr_rd;
    logic [XLEN-1:0] div_wr_data;
    logic            force_wb;
    logic [4:0]      haz_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pend_rd_q  <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_rd_q  <= pend_rd_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        wait_cnt_d  = wait_cnt_q;
        div_wr      = 1'b0;
        div_wr_rd   = buf_rd_q;
        div_wr_data = buf_data_q;
        force_wb    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_issue_i) begin
                    state_d   = PEND;
                    pend_rd_d = div_issue_rd_i;
                end
            end
            PEND: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    if (pend_rd_q == 5'd0) begin
                        state_d = IDLE;
                    end else if (!pipe_wb_en_i) begin
                        div_wr      = 1'b1;
                        div_wr_rd   = div_rd_i;
                        div_wr_data = div_result_i;
                        state_d     = IDLE;
                    end else begin
                        buf_rd_d   = div_rd_i;
                        buf_data_d = div_result_i;
                        wait_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // The result is already committed, so flush has no effect here.
                if (wait_cnt_q == MaxWait) begin
                    force_wb = 1'b1;
                    div_wr   = 1'b1;
                    state_d  = IDLE;
                end else if (!pipe_wb_en_i) begin
                    div_wr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port mux: forced drain > pipeline > divide source.
    always_comb begin
        rf_we_o         = 1'b0;
        rf_rd_o         = '0;
        rf_wdata_o      = '0;
        pipe_wb_stall_o = 1'b0;
        if (reset_n) begin
            pipe_wb_stall_o = force_wb;
            if (force_wb) begin
                rf_rd_o    = buf_rd_q;
                rf_wdata_o = buf_data_q;
                rf_we_o    = (buf_rd_q != 5'd0);
            end else if (pipe_wb_en_i) begin
                rf_rd_o    = pipe_wb_rd_i;
                rf_wdata_o = pipe_wb_data_i;
                rf_we_o    = (pipe_wb_rd_i != 5'd0);
            end else if (div_wr) begin
                rf_rd_o    = div_wr_rd;
                rf_wdata_o = div_wr_data;
                rf_we_o    = (div_wr_rd != 5'd0);
            end
        end
    end

    // No bypass: the hazard stays up through the write-through cycle.
    assign haz_rd     = (state_q == HOLD) ? buf_rd_q : pend_rd_q;
    assign id_stall_o = (state_q != IDLE) &&
                        (id_is_div_i ||
                         ((haz_rd != 5'd0) &&
                          (id_rs1_i == haz_rd || id_rs2_i == haz_rd || id_rd_i == haz_rd)));

    a_issue_only_idle: assert property (@(posedge clk) disable iff (!reset_n)
        div_issue_i |-> state_q == IDLE);
    a_ready_only_pend: assert property (@(posedge clk) disable iff (!reset_n)
        div_ready_i |-> state_q == PEND);

endmodule

// File: tb/tb_div_wb_ctrl.sv
module tb_div_wb_ctrl;
    import rv_m_pkg::*;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned XLEN     = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            div_issue_i;
    logic [4:0]      div_issue_rd_i;
    logic            flush_i;
    logic            div_ready_i;
    logic [4:0]      div_rd_i;
    logic [XLEN-1:0] div_result_i;
    logic            pipe_wb_en_i;
    logic [4:0]      pipe_wb_rd_i;
    logic [XLEN-1:0] pipe_wb_data_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic            id_is_div_i;
    logic            rf_we_o;
    logic [4:0]      rf_rd_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            id_stall_o;
    logic            pipe_wb_stall_o;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding divide, optionally parked in a buffer.
    bit              m_inflight, m_buffered;
    logic [4:0]      m_dest, m_brd;
    logic [XLEN-1:0] m_bdata;
    int unsigned     m_age;

    // Last sampled DUT outputs, for the hand-computed expectations.
    logic            s_we, s_ids, s_ps;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_data;

    div_wb_ctrl #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .div_issue_i    (div_issue_i),
        .div_issue_rd_i (div_issue_rd_i),
        .flush_i        (flush_i),
        .div_ready_i    (div_ready_i),
        .div_rd_i       (div_rd_i),
        .div_result_i   (div_result_i),
        .pipe_wb_en_i   (pipe_wb_en_i),
        .pipe_wb_rd_i   (pipe_wb_rd_i),
        .pipe_wb_data_i (pipe_wb_data_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rd_i        (id_rd_i),
        .id_is_div_i    (id_is_div_i),
        .rf_we_o        (rf_we_o),
        .rf_rd_o        (rf_rd_o),
        .rf_wdata_o     (rf_wdata_o),
        .id_stall_o     (id_stall_o),
        .pipe_wb_stall_o(pipe_wb_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        div_issue_i = 0; div_issue_rd_i = 0; flush_i = 0;
        div_ready_i = 0; div_rd_i = 0; div_result_i = 0;
        pipe_wb_en_i = 0; pipe_wb_rd_i = 0; pipe_wb_data_i = 0;
        id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_is_div_i = 0;
    endtask

    function automatic bit model_idle();
        return !m_inflight && !m_buffered;
    endfunction

    // Compare the current cycle against the model, then advance one clock.
    task automatic step();
        logic            e_we, e_ps, e_ids, dv;
        logic [4:0]      e_rd, dv_rd, hz;
        logic [XLEN-1:0] e_data, dv_data;
        #1;
        dv = 0; dv_rd = 0; dv_data = 0; e_ps = 0; hz = m_dest;
        if (m_buffered) begin
            hz = m_brd; dv_rd = m_brd; dv_data = m_bdata;
            if (m_age == MAX_WAIT) e_ps = 1;
            else dv = !pipe_wb_en_i;
        end else if (m_inflight && div_ready_i && !flush_i && m_dest != 0 && !pipe_wb_en_i) begin
            dv = 1; dv_rd = div_rd_i; dv_data = div_result_i;
        end
        e_rd = 0; e_data = 0; e_we = 0;
        if (e_ps) begin
            e_rd = m_brd; e_data = m_bdata;
        end else if (pipe_wb_en_i) begin
            e_rd = pipe_wb_rd_i; e_data = pipe_wb_data_i;
        end else if (dv) begin
            e_rd = dv_rd; e_data = dv_data;
        end
        e_we = (e_ps || pipe_wb_en_i || dv) && (e_rd != 0);
        e_ids = (m_inflight || m_buffered) &&
                (id_is_div_i || (hz != 0 && (id_rs1_i == hz || id_rs2_i == hz || id_rd_i == hz)));

        s_we = rf_we_o; s_rd = rf_rd_o; s_data = rf_wdata_o; s_ids = id_stall_o;
        s_ps = pipe_wb_stall_o;
        chk("we", 32'(s_we), 32'(e_we));
        chk("id_stall", 32'(s_ids), 32'(e_ids));
        chk("pipe_wb_stall", 32'(s_ps), 32'(e_ps));
        if (e_we) begin
            chk("rf_rd", 32'(s_rd), 32'(e_rd));
            chk("rf_wdata", s_data, e_data);
        end

        @(posedge clk);
        if (m_buffered) begin
            if (e_ps || !pipe_wb_en_i) m_buffered = 0;
            else m_age++;
        end else if (m_inflight) begin
            if (flush_i) begin
                m_inflight = 0;
            end else if (div_ready_i) begin
                m_inflight = 0;
                if (m_dest != 0 && pipe_wb_en_i) begin
                    m_buffered = 1; m_brd = div_rd_i; m_bdata = div_result_i; m_age = 0;
                end
            end
        end else if (div_issue_i) begin
            m_inflight = 1; m_dest = div_issue_rd_i;
        end
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 0;
        #1;
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_rd", 32'(rf_rd_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_id_stall", 32'(id_stall_o), 32'd0);
        chk("rst_pipe_stall", 32'(pipe_wb_stall_o), 32'd0);
        m_inflight = 0; m_buffered = 0; m_dest = 0; m_brd = 0; m_bdata = 0; m_age = 0;
        repeat (cycles) @(posedge clk);
        #2 reset_n = 1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle_in();
        div_issue_i = 1; div_issue_rd_i = rd;
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        reset_n = 0;
        pipe_wb_en_i = 1; pipe_wb_rd_i = 5'd3; id_is_div_i = 1;
        #2;
        apply_reset(2);

        // Write-through with idle pipeline.
        issue(5'd10);
        step();
        div_ready_i = 1; div_rd_i = 5'd10; div_result_i = 32'hFFFF_FFFB;
        step();
        chk("t1_we", 32'(s_we), 32'd1);
        chk("t1_rd", 32'(s_rd), 32'd10);
        chk("t1_data", s_data, 32'hFFFF_FFFB);
        idle_in(); id_rs1_i = 5'd10;
        step();
        chk("t1_idle_nostall", 32'(s_ids), 32'd0);

        // Decode hazards while pending.
        issue(5'd10);
        id_rs1_i = 5'd10; step(); chk("t2_raw", 32'(s_ids), 32'd1);
        id_rs1_i = 5'd11; step(); chk("t2_nohaz", 32'(s_ids), 32'd0);
        id_is_div_i = 1;  step(); chk("t2_div", 32'(s_ids), 32'd1);
        idle_in(); id_rs1_i = 5'd10;
        div_ready_i = 1; div_rd_i = 5'd10; div_result_i = 32'h1;
        step(); chk("t2_wt_stall", 32'(s_ids), 32'd1); chk("t2_wt_we", 32'(s_we), 32'd1);
        idle_in(); id_rs1_i = 5'd10;
        step(); chk("t2_after", 32'(s_ids), 32'd0);

        // Pipeline wins, divide drains next cycle.
        issue(5'd5);
        div_ready_i = 1; div_rd_i = 5'd5; div_result_i = 32'd4;
        pipe_wb_en_i = 1; pipe_wb_rd_i = 5'd7; pipe_wb_data_i = 32'h55;
        step();
        chk("t3_pipe_rd", 32'(s_rd), 32'd7); chk("t3_pipe_data", s_data, 32'h55);
        idle_in(); step();
        chk("t3_div_we", 32'(s_we), 32'd1);
        chk("t3_div_rd", 32'(s_rd), 32'd5); chk("t3_div_data", s_data, 32'd4);

        // Bounded wait: MAX_WAIT pipe writes then a forced drain.
        issue(5'd5);
        div_ready_i = 1; div_rd_i = 5'd5; div_result_i = 32'h1234;
        pipe_wb_en_i = 1; pipe_wb_rd_i = 5'd7; pipe_wb_data_i = 32'h66;
        step();
        div_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_wait_ps", 32'(s_ps), 32'd0); chk("t4_wait_rd", 32'(s_rd), 32'd7);
        end
        step();
        chk("t4_force_ps", 32'(s_ps), 32'd1); chk("t4_force_rd", 32'(s_rd), 32'd5);
        chk("t4_force_data", s_data, 32'h1234);
        step();
        chk("t4_after_ps", 32'(s_ps), 32'd0); chk("t4_after_rd", 32'(s_rd), 32'd7);

        // Flush coincident with completion.
        issue(5'd12);
        flush_i = 1; div_ready_i = 1; div_rd_i = 5'd12; div_result_i = 32'hAB;
        step(); chk("t5_no_we", 32'(s_we), 32'd0);
        idle_in(); id_rs1_i = 5'd12;
        step(); chk("t5_no_stall", 32'(s_ids), 32'd0);

        // x0 destination, then reset while holding.
        issue(5'd0);
        id_rs1_i = 5'd0; step(); chk("t6_x0_nostall", 32'(s_ids), 32'd0);
        idle_in(); div_ready_i = 1; div_rd_i = 5'd0; div_result_i = 32'h7FFF_FFFF;
        step(); chk("t6_x0_we", 32'(s_we), 32'd0);
        issue(5'd5);
        div_ready_i = 1; div_rd_i = 5'd5; div_result_i = 32'h99;
        pipe_wb_en_i = 1; pipe_wb_rd_i = 5'd7; pipe_wb_data_i = 32'h77;
        step();
        idle_in(); pipe_wb_en_i = 1; pipe_wb_rd_i = 5'd7; id_is_div_i = 1;
        apply_reset(2);
        idle_in(); id_is_div_i = 1;
        step();
        chk("t6_post_we", 32'(s_we), 32'd0); chk("t6_post_stall", 32'(s_ids), 32'd0);

        // Randomized traffic, respecting the legal issue/ready protocol.
        idle_in();
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            pipe_wb_en_i   = ($urandom_range(0, 1) == 1);
            pipe_wb_rd_i   = 5'($urandom_range(0, 7));
            pipe_wb_data_i = $urandom;
            id_rs1_i       = 5'($urandom_range(0, 7));
            id_rs2_i       = 5'($urandom_range(0, 7));
            id_rd_i        = 5'($urandom_range(0, 7));
            id_is_div_i    = ($urandom_range(0, 7) == 0);
            div_rd_i       = 5'($urandom_range(0, 31));
            div_result_i   = $urandom;
            if (model_idle()) begin
                div_issue_i    = ($urandom_range(0, 2) == 0);
                div_issue_rd_i = 5'($urandom_range(0, 7));
            end else begin
                flush_i = ($urandom_range(0, 19) == 0);
                if (m_inflight) begin
                    div_ready_i = ($urandom_range(0, 3) == 0);
                    div_rd_i    = m_dest;
                end
            end
            if ($urandom_range(0, 299) == 0) apply_reset(1);
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_wb_ctrl.md
Name: div_wb_ctrl

Overview:
Downstream companion of div_unit. It captures each divide/remainder completion (ready/rd/result pulse) and merges it onto the single register-file write port shared with the main pipeline writeback. It also tracks the one outstanding divide destination and raises decode stalls on RAW/WAW hazards and on new divides while one is in flight. Pipeline writeback normally has priority; a bounded-wait counter guarantees the divide result is eventually written.

Parameters:
MAX_WAIT, 4, cycles a buffered divide result may wait before pipeline writeback is pre-empted (1..15)
XLEN, 32, data width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
div_issue_i  in  1  divide accepted this cycle (same cycle as div_unit start_i/valid_i)
div_issue_rd_i  in  5  destination of issued divide
flush_i  in  1  pipeline flush (same signal driven to div_unit flush_i)
div_ready_i  in  1  div_unit ready_o (1-cycle pulse)
div_rd_i  in  5  div_unit rd_o
div_result_i  in  XLEN  div_unit result_o
pipe_wb_en_i  in  1  main pipeline writeback request
pipe_wb_rd_i  in  5  main pipeline writeback rd
pipe_wb_data_i  in  XLEN  main pipeline writeback data
id_rs1_i  in  5  decode source 1
id_rs2_i  in  5  decode source 2
id_rd_i  in  5  decode destination
id_is_div_i  in  1  decode instruction is DIV/DIVU/REM/REMU
rf_we_o  out  1  register-file write enable
rf_rd_o  out  5  register-file write address
rf_wdata_o  out  XLEN  register-file write data
id_stall_o  out  1  stall decode
pipe_wb_stall_o  out  1  pipeline writeback pre-empted; pipeline holds its wb values this cycle

Behaviour:
- Reset: state IDLE, pend_rd=0, buf_rd=0, buf_data=0, wait_cnt=0. While reset is active, all outputs are 0.
- States: IDLE, PEND (divide in flight), HOLD (result buffered, awaiting port).
- IDLE: div_issue_i -> PEND, pend_rd <= div_issue_rd_i.
- PEND:
  - flush_i -> IDLE; a div_ready_i in the same cycle is discarded.
  - div_ready_i with pend_rd==0 -> IDLE, no write.
  - div_ready_i with !pipe_wb_en_i -> write-through in the same cycle (rf_we_o=1, rf_rd_o=div_rd_i, rf_wdata_o=div_result_i) -> IDLE.
  - div_ready_i with pipe_wb_en_i -> buf_rd/buf_data captured, wait_cnt <= 0 -> HOLD.
- HOLD (flush_i ignored; result is committed):
  - !pipe_wb_en_i -> write buffer -> IDLE.
  - Otherwise, if wait_cnt < MAX_WAIT: wait_cnt increments.
  - wait_cnt==MAX_WAIT: pipe_wb_stall_o=1 (combinational), buffer is written regardless of pipe_wb_en_i -> IDLE.
- Port mux (combinational): pipe_wb_stall_o ? buffer : pipe_wb_en_i ? pipeline : divide source (write-through or HOLD). rf_we_o=0 when the selected rd==0.
- id_stall_o (combinational) = state!=IDLE && (id_is_div_i || (pend_rd!=0 && (id_rs1_i==pend_rd || id_rs2_i==pend_rd || id_rd_i==pend_rd))).
  - In HOLD the hazard register is buf_rd.
  - On the write-through cycle the hazard against pend_rd is still asserted; there is no bypass.
- div_issue_i outside IDLE is illegal (prevented by id_stall_o); SVA assertion flags it.
- div_ready_i in IDLE or HOLD is ignored; SVA flags it.
- Reset mid-operation: immediate return to IDLE, buffer discarded.

Decomposition:
- Shared package rv_m_pkg: wb_state_e enum {IDLE, PEND, HOLD}; funct3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111; XLEN default.
- No sub-module; the scoreboard is one register and the FSM/mux are small enough to keep flat.

Test Plan:
- Issue rd=10, then ready with result 0xFFFFFFFB and pipe idle -> same cycle rf_we_o=1, rf_rd_o=10, rf_wdata_o=0xFFFFFFFB; IDLE next cycle.
- Issue rd=10; decode rs1=10 during PEND -> id_stall_o=1 until the cycle after the write. Decode rs1=11 -> id_stall_o=0. Decode another DIV -> id_stall_o=1.
- Ready (rd=5, data=4) while pipe_wb_en_i=1 (rd=7, data=0x55) -> pipe write to x7 that cycle; HOLD. Pipe goes idle next cycle -> x5<=4.
- Ready into HOLD, pipe_wb_en_i held high with MAX_WAIT=4 -> 4 pipe writes, then pipe_wb_stall_o=1 for one cycle with x5<=buffer, then IDLE.
- Issue rd=12, flush_i coincident with div_ready_i -> no write, IDLE, id_stall_o=0.
- Issue rd=0, ready with data 0x7FFFFFFF -> rf_we_o=0, no stall on rs1=0; reset asserted in HOLD -> all outputs 0 and no write after release.
